pio_sm_datapath: RTL and testbench
==================================

Name: pio_sm_datapath

Overview:
Datapath core of one PIO state machine. It holds a 5-bit program counter with wrap and jump support, and two 4-deep 32-bit FIFOs. The TX FIFO is written by the system bus and read by the state machine. The RX FIFO is written by the state machine and read by the system bus. The instruction decoder/FSM sits above this block and drives its control inputs.

Parameters:
DATA_W, 32, FIFO word width
DEPTH, 4, entries per FIFO (power of two, ≥2)
PC_W, 5, program counter / instruction address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wrap_top  in  PC_W  wrap target (first address of the loop)
wrap_bottom  in  PC_W  wrap source (last address of the loop)
jump  in  PC_W  jump target address
jump_en  in  1  load jump into pc
pc_en  in  1  advance/update pc this cycle
pc  out  PC_W  current instruction address
tx_push  in  1  bus writes tx_data_in
tx_data_in  in  DATA_W  bus write data
tx_pop  in  1  state machine consumes TX head
tx_data_out  out  DATA_W  TX head word
tx_status  out  2  {full, empty}
tx_count  out  3  TX occupancy 0..4
rx_push  in  1  state machine writes rx_data_in
rx_data_in  in  DATA_W  state machine write data
rx_pop  in  1  bus consumes RX head
rx_data_out  out  DATA_W  RX head word
rx_status  out  2  {full, empty}
rx_count  out  3  RX occupancy 0..4

Behaviour:
- Reset:
  - pc=0.
  - Both FIFOs: count=0, status=2'b01 (empty), pointers=0, data_out=0.
  - Reset mid-operation discards all FIFO contents immediately.
- PC update on posedge clk, evaluated in priority order:
  1. pc_en=0: pc holds; jump_en is ignored.
  2. jump_en=1: pc←jump, even if jump==wrap_bottom.
  3. pc==wrap_bottom: pc←wrap_top.
  4. Otherwise: pc←pc+1, modulo 2^PC_W (31→0 when wrap_bottom≠31).
- wrap_top > wrap_bottom is legal; the plain increment and wrap rules still apply.
- FIFOs are synchronous, first-word fall-through:
  - data_out continuously shows the oldest entry, with no pop latency.
  - data_out is 0 when empty.
  - Write pointer and read pointer are each log2(DEPTH) bits and wrap naturally.
- Push with count<DEPTH: word stored at the write pointer; pointer+1; count+1.
- Push with count==DEPTH: word dropped; state unchanged.
- Pop with count>0: read pointer+1; count−1.
- Pop with count==0: ignored.
- Push and pop in the same cycle:
  - Empty: push only; count 0→1.
  - Full: both accepted; count stays 4; the new word lands in the freed slot.
  - Otherwise: both accepted; count unchanged.
- status[0]=(count==0), status[1]=(count==DEPTH). Both are combinational from the registered count.
- count is registered and updates on the clock edge following the operation.

Optional Feature:
PIO_FIFO_ERR_EN:
- When defined, adds outputs tx_err and rx_err (1 bit each).
- An error sets when that FIFO sees a push while full without a same-cycle pop, or a pop while empty.
- Errors are sticky until rst.
- When undefined, these ports and their logic are absent, and illegal operations are silently ignored as above.

Decomposition:
- Shared package pio_pkg holds:
  - FIFO status bit indices: FIFO_EMPTY=0, FIFO_FULL=1.
  - Default widths: DATA_W=32, DEPTH=4, PC_W=5.
- One sub-module, pio_fifo, is instantiated twice (TX, RX).
- PC logic is inline in pio_sm_datapath.

Test Plan:
1. rst pulse mid-cycle → pc=0 asynchronously, tx/rx count=0, status=2'b01, data_out=0.
2. wrap_top=0, wrap_bottom=31, pc_en=1 for 33 cycles → pc 0..31 then 0, 1. Then wrap_top=4, wrap_bottom=6 → pc 4,5,6,4.
3. pc=10, jump=3, jump_en=1, pc_en=1 → pc=3. Same with pc_en=0 → pc stays 10.
4. Push 0xA,0xB,0xC,0xD,0xE to TX → count 1..4, status=2'b10, 0xE dropped. Pop ×4 → data_out 0xA,0xB,0xC,0xD, then count=0, status=2'b01.
5. RX holds 4 words (full); push 0x55 and pop in the same cycle → count stays 4, head advances, 0x55 becomes the last out. Pop on empty → count stays 0.
6. Empty TX, push+pop in the same cycle → count=1, data_out=pushed word. With PIO_FIFO_ERR_EN, a pop on empty sets tx_err=1, which holds until rst.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants for the PIO state machine datapath.
// FIFO status bit positions and default widths.
package pio_pkg;

    localparam int FIFO_EMPTY = 0;
    localparam int FIFO_FULL  = 1;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int PC_W   = 5;

endpackage

// File: rtl/pio_fifo.sv
// First-word fall-through FIFO used for both PIO TX and RX paths.
// Optional sticky error flag under PIO_FIFO_ERR_EN.
module pio_fifo
    import pio_pkg::*;
#(
    parameter int DATA_W = pio_pkg::DATA_W,
    parameter int DEPTH  = pio_pkg::DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        status,
`ifdef PIO_FIFO_ERR_EN
    output logic              err,
`endif
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              empty;
    logic              full;
    logic              pop_ok;
    logic              push_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop on a full FIFO frees the slot the push lands in.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign status[FIFO_EMPTY] = empty;
    assign status[FIFO_FULL]  = full;
    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef PIO_FIFO_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((push && full && !pop) || (pop && empty)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/pio_sm_datapath.sv
// PIO state machine datapath: wrapping program counter plus TX/RX FIFOs.
// Define PIO_FIFO_ERR_EN to add sticky tx_err/rx_err outputs.
module pio_sm_datapath
    import pio_pkg::*;
#(
    parameter int DATA_W = pio_pkg::DATA_W,
    parameter int DEPTH  = pio_pkg::DEPTH,
    parameter int PC_W   = pio_pkg::PC_W,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   wrap_top,
    input  logic [PC_W-1:0]   wrap_bottom,
    input  logic [PC_W-1:0]   jump,
    input  logic              jump_en,
    input  logic              pc_en,
    output logic [PC_W-1:0]   pc,
    input  logic              tx_push,
    input  logic [DATA_W-1:0] tx_data_in,
    input  logic              tx_pop,
    output logic [DATA_W-1:0] tx_data_out,
    output logic [1:0]        tx_status,
    output logic [CW-1:0]     tx_count,
`ifdef PIO_FIFO_ERR_EN
    output logic              tx_err,
    output logic              rx_err,
`endif
    input  logic              rx_push,
    input  logic [DATA_W-1:0] rx_data_in,
    input  logic              rx_pop,
    output logic [DATA_W-1:0] rx_data_out,
    output logic [1:0]        rx_status,
    output logic [CW-1:0]     rx_count
);

    // Jump beats the wrap so a jump onto wrap_bottom lands there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (pc_en) begin
            if (jump_en) begin
                pc <= jump;
            end else if (pc == wrap_bottom) begin
                pc <= wrap_top;
            end else begin
                pc <= pc + PC_W'(1);
            end
        end
    end

    pio_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push),
        .data_in  (tx_data_in),
        .pop      (tx_pop),
        .data_out (tx_data_out),
        .status   (tx_status),
`ifdef PIO_FIFO_ERR_EN
        .err      (tx_err),
`endif
        .count    (tx_count)
    );

    pio_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .data_in  (rx_data_in),
        .pop      (rx_pop),
        .data_out (rx_data_out),
        .status   (rx_status),
`ifdef PIO_FIFO_ERR_EN
        .err      (rx_err),
`endif
        .count    (rx_count)
    );

endmodule

// File: tb/tb_pio_sm_datapath.sv
// Self-checking bench for pio_sm_datapath against a queue-based model.
// Error-flag checks are compiled in only with PIO_FIFO_ERR_EN.
module tb_pio_sm_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wrap_top, wrap_bottom, jump;
    logic        jump_en, pc_en;
    logic [4:0]  pc;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0] tx_data_in, tx_data_out;
    logic [31:0] rx_data_in, rx_data_out;
    logic [1:0]  tx_status, rx_status;
    logic [2:0]  tx_count, rx_count;
`ifdef PIO_FIFO_ERR_EN
    logic        tx_err, rx_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [4:0]  m_pc;
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic        m_txerr, m_rxerr;

    always #5 clk = ~clk;

    pio_sm_datapath dut (
        .clk         (clk),
        .rst         (rst),
        .wrap_top    (wrap_top),
        .wrap_bottom (wrap_bottom),
        .jump        (jump),
        .jump_en     (jump_en),
        .pc_en       (pc_en),
        .pc          (pc),
        .tx_push     (tx_push),
        .tx_data_in  (tx_data_in),
        .tx_pop      (tx_pop),
        .tx_data_out (tx_data_out),
        .tx_status   (tx_status),
        .tx_count    (tx_count),
`ifdef PIO_FIFO_ERR_EN
        .tx_err      (tx_err),
        .rx_err      (rx_err),
`endif
        .rx_push     (rx_push),
        .rx_data_in  (rx_data_in),
        .rx_pop      (rx_pop),
        .rx_data_out (rx_data_out),
        .rx_status   (rx_status),
        .rx_count    (rx_count)
    );

    task automatic model_reset();
        m_pc = '0;
        txq.delete();
        rxq.delete();
        m_txerr = 1'b0;
        m_rxerr = 1'b0;
    endtask

    // Advance the model by the spec rules, then one clock, sample at +1.
    task automatic tick();
        logic [4:0] npc;
        bit         popok;
        npc = m_pc;
        if (pc_en) begin
            if (jump_en) npc = jump;
            else if (m_pc == wrap_bottom) npc = wrap_top;
            else npc = m_pc + 5'd1;
        end
        if ((tx_push && txq.size() == 4 && !tx_pop) ||
            (tx_pop && txq.size() == 0)) m_txerr = 1'b1;
        if ((rx_push && rxq.size() == 4 && !rx_pop) ||
            (rx_pop && rxq.size() == 0)) m_rxerr = 1'b1;
        popok = tx_pop && txq.size() > 0;
        if (popok) void'(txq.pop_front());
        if (tx_push && txq.size() < 4) txq.push_back(tx_data_in);
        popok = rx_pop && rxq.size() > 0;
        if (popok) void'(rxq.pop_front());
        if (rx_push && rxq.size() < 4) rxq.push_back(rx_data_in);
        @(posedge clk);
        #1;
        m_pc = npc;
    endtask

    task automatic idle_inputs();
        jump_en = 0; pc_en = 0;
        tx_push = 0; tx_pop = 0;
        rx_push = 0; rx_pop = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        wrap_top = 0; wrap_bottom = 31;
        pc_en = 1;
        tx_push = 1; tx_data_in = 32'hDEAD_BEEF;
        rx_push = 1; rx_data_in = 32'hCAFE_F00D;
        repeat (3) tick();
        idle_inputs();
        #3 rst = 1;
        #1;
        model_reset();
        checks++;
        if (pc !== 5'd0) begin
            errors++;
            $display("FAIL reset_pc got %0d exp 0", pc);
        end
        checks++;
        if (tx_count !== 3'd0 || tx_status !== 2'b01) begin
            errors++;
            $display("FAIL reset_tx got cnt %0d st %b exp 0 01",
                     tx_count, tx_status);
        end
        checks++;
        if (rx_count !== 3'd0 || rx_status !== 2'b01) begin
            errors++;
            $display("FAIL reset_rx got cnt %0d st %b exp 0 01",
                     rx_count, rx_status);
        end
        checks++;
        if (tx_data_out !== 32'd0 || rx_data_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got %h %h exp 0 0",
                     tx_data_out, rx_data_out);
        end
`ifdef PIO_FIFO_ERR_EN
        checks++;
        if (tx_err !== 1'b0 || rx_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b %b exp 0 0", tx_err, rx_err);
        end
`endif
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_pc_wrap();
        idle_inputs();
        wrap_top = 0; wrap_bottom = 31; pc_en = 1;
        for (int k = 1; k <= 33; k++) begin
            tick();
            checks++;
            if (pc !== 5'(k % 32)) begin
                errors++;
                $display("FAIL pc_seq got %0d exp %0d", pc, k % 32);
            end
        end
        jump = 4; jump_en = 1;
        tick();
        jump_en = 0;
        wrap_top = 4; wrap_bottom = 6;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (pc !== 5'(4 + (k + 1) % 3)) begin
                errors++;
                $display("FAIL pc_wrap got %0d exp %0d",
                         pc, 4 + (k + 1) % 3);
            end
        end
        idle_inputs();
    endtask

    task automatic test_jump();
        idle_inputs();
        wrap_top = 0; wrap_bottom = 31;
        pc_en = 1; jump_en = 1; jump = 10;
        tick();
        jump = 3;
        tick();
        checks++;
        if (pc !== 5'd3) begin
            errors++;
            $display("FAIL jump got %0d exp 3", pc);
        end
        jump = 10;
        tick();
        pc_en = 0; jump = 3;
        tick();
        checks++;
        if (pc !== 5'd10) begin
            errors++;
            $display("FAIL jump_hold got %0d exp 10", pc);
        end
        pc_en = 1; jump = 31; wrap_bottom = 31; wrap_top = 7;
        tick();
        checks++;
        if (pc !== 5'd31) begin
            errors++;
            $display("FAIL jump_bottom got %0d exp 31", pc);
        end
        jump_en = 0;
        tick();
        checks++;
        if (pc !== 5'd7) begin
            errors++;
            $display("FAIL wrap_from_31 got %0d exp 7", pc);
        end
        idle_inputs();
    endtask

    task automatic test_tx_fill();
        logic [31:0] words [5];
        words = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
        idle_inputs();
        tx_push = 1;
        for (int i = 0; i < 5; i++) begin
            tx_data_in = words[i];
            tick();
            checks++;
            if (tx_count !== 3'(i < 4 ? i + 1 : 4)) begin
                errors++;
                $display("FAIL tx_fill_cnt got %0d exp %0d",
                         tx_count, i < 4 ? i + 1 : 4);
            end
        end
        tx_push = 0;
        checks++;
        if (tx_status !== 2'b10) begin
            errors++;
            $display("FAIL tx_full_st got %b exp 10", tx_status);
        end
        tx_pop = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_data_out !== words[i]) begin
                errors++;
                $display("FAIL tx_head got %h exp %h",
                         tx_data_out, words[i]);
            end
            tick();
        end
        tx_pop = 0;
        checks++;
        if (tx_count !== 3'd0 || tx_status !== 2'b01 ||
            tx_data_out !== 32'd0) begin
            errors++;
            $display("FAIL tx_drain got cnt %0d st %b d %h exp 0 01 0",
                     tx_count, tx_status, tx_data_out);
        end
    endtask

    task automatic test_rx_full_pushpop();
        logic [31:0] w [4];
        idle_inputs();
        rx_push = 1;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom();
            rx_data_in = w[i];
            tick();
        end
        rx_pop = 1; rx_data_in = 32'h55;
        tick();
        rx_push = 0;
        checks++;
        if (rx_count !== 3'd4 || rx_data_out !== w[1]) begin
            errors++;
            $display("FAIL rx_full_pp got cnt %0d d %h exp 4 %h",
                     rx_count, rx_data_out, w[1]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_data_out !== (i < 3 ? w[i + 1] : 32'h55)) begin
                errors++;
                $display("FAIL rx_order got %h exp %h", rx_data_out,
                         i < 3 ? w[i + 1] : 32'h55);
            end
            tick();
        end
        tick();
        rx_pop = 0;
        checks++;
        if (rx_count !== 3'd0 || rx_status !== 2'b01) begin
            errors++;
            $display("FAIL rx_pop_empty got cnt %0d st %b exp 0 01",
                     rx_count, rx_status);
        end
`ifdef PIO_FIFO_ERR_EN
        checks++;
        if (rx_err !== 1'b1) begin
            errors++;
            $display("FAIL rx_err got %b exp 1", rx_err);
        end
`endif
    endtask

    task automatic test_empty_pushpop();
        idle_inputs();
        tx_push = 1; tx_pop = 1; tx_data_in = 32'h1234_5678;
        tick();
        idle_inputs();
        checks++;
        if (tx_count !== 3'd1 || tx_data_out !== 32'h1234_5678) begin
            errors++;
            $display("FAIL tx_empty_pp got cnt %0d d %h exp 1 12345678",
                     tx_count, tx_data_out);
        end
        tx_pop = 1;
        tick();
        tick();
        idle_inputs();
        repeat (3) tick();
        checks++;
        if (tx_count !== 3'd0) begin
            errors++;
            $display("FAIL tx_pop_empty got %0d exp 0", tx_count);
        end
`ifdef PIO_FIFO_ERR_EN
        checks++;
        if (tx_err !== 1'b1) begin
            errors++;
            $display("FAIL tx_err_sticky got %b exp 1", tx_err);
        end
        #2 rst = 1;
        #1;
        model_reset();
        checks++;
        if (tx_err !== 1'b0) begin
            errors++;
            $display("FAIL tx_err_clr got %b exp 0", tx_err);
        end
        @(posedge clk);
        #1 rst = 0;
`endif
    endtask

    task automatic test_random();
        logic [1:0] es;
        logic [31:0] ed;
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) begin
                wrap_top = 5'($urandom_range(0, 31));
                wrap_bottom = 5'($urandom_range(0, 31));
            end
            pc_en = ($urandom_range(0, 3) != 0);
            jump_en = ($urandom_range(0, 7) == 0);
            jump = 5'($urandom());
            tx_push = $urandom_range(0, 1) == 1;
            tx_pop = $urandom_range(0, 2) == 0;
            rx_push = $urandom_range(0, 2) == 0;
            rx_pop = $urandom_range(0, 1) == 1;
            tx_data_in = $urandom();
            rx_data_in = $urandom();
            tick();
            checks++;
            if (pc !== m_pc) begin
                errors++;
                $display("FAIL rnd_pc got %0d exp %0d", pc, m_pc);
            end
            es = {txq.size() == 4, txq.size() == 0};
            ed = txq.size() > 0 ? txq[0] : 32'd0;
            checks++;
            if (tx_count !== 3'(txq.size()) || tx_status !== es ||
                tx_data_out !== ed) begin
                errors++;
                $display("FAIL rnd_tx got %0d %b %h exp %0d %b %h",
                         tx_count, tx_status, tx_data_out,
                         txq.size(), es, ed);
            end
            es = {rxq.size() == 4, rxq.size() == 0};
            ed = rxq.size() > 0 ? rxq[0] : 32'd0;
            checks++;
            if (rx_count !== 3'(rxq.size()) || rx_status !== es ||
                rx_data_out !== ed) begin
                errors++;
                $display("FAIL rnd_rx got %0d %b %h exp %0d %b %h",
                         rx_count, rx_status, rx_data_out,
                         rxq.size(), es, ed);
            end
`ifdef PIO_FIFO_ERR_EN
            checks++;
            if (tx_err !== m_txerr || rx_err !== m_rxerr) begin
                errors++;
                $display("FAIL rnd_err got %b %b exp %b %b",
                         tx_err, rx_err, m_txerr, m_rxerr);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        wrap_top = 0; wrap_bottom = 31; jump = 0;
        tx_data_in = 0; rx_data_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_pc_wrap();
        test_jump();
        test_tx_fill();
        test_rx_full_pushpop();
        test_empty_pushpop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
